// File: rtl/music_timer_pkg.sv
// Shared definitions for the note-duration timer: length codes, articulation
// and FSM encodings, and the length-code to sixteenth-step mapping.
package music_timer_pkg;

  localparam logic [3:0] LEN_NONE        = 4'd0;
  localparam logic [3:0] LEN_WHOLE       = 4'd1;
  localparam logic [3:0] LEN_HALF        = 4'd2;
  localparam logic [3:0] LEN_QUARTER     = 4'd3;
  localparam logic [3:0] LEN_EIGHTH      = 4'd4;
  localparam logic [3:0] LEN_DOT_HALF    = 4'd5;
  localparam logic [3:0] LEN_DOT_QUARTER = 4'd6;
  localparam logic [3:0] LEN_DOT_EIGHTH  = 4'd7;
  localparam logic [3:0] LEN_SIXTEENTH   = 4'd8;

  typedef enum logic [1:0] {
    ARTIC_LEGATO   = 2'd0,
    ARTIC_NORMAL   = 2'd1,
    ARTIC_STACCATO = 2'd2,
    ARTIC_REST     = 2'd3
  } artic_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  // Number of sixteenth steps for a length code; 0 marks a stop command.
  function automatic logic [4:0] len_to_steps(input logic [3:0] code);
    case (code)
      LEN_WHOLE:       len_to_steps = 5'd16;
      LEN_HALF:        len_to_steps = 5'd8;
      LEN_QUARTER:     len_to_steps = 5'd4;
      LEN_EIGHTH:      len_to_steps = 5'd2;
      LEN_DOT_HALF:    len_to_steps = 5'd12;
      LEN_DOT_QUARTER: len_to_steps = 5'd6;
      LEN_DOT_EIGHTH:  len_to_steps = 5'd3;
      LEN_SIXTEENTH:   len_to_steps = 5'd1;
      default:         len_to_steps = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step prescaler: counts 0..tick_len-1, holds when not enabled, flags the
// terminal count and exposes the next count for registered output decode.
module tick_prescaler #(
  parameter int unsigned TICK_W = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [TICK_W-1:0] tick_len,
  output logic [TICK_W-1:0] count,
  output logic [TICK_W-1:0] count_nxt,
  output logic              wrap
);

  assign wrap = (count == tick_len - TICK_W'(1));

  always_comb begin
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (en)
      count_nxt = wrap ? '0 : count + TICK_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_nxt;
  end

endmodule

// File: rtl/note_length_timer.sv
// Note-duration timer: accepts one note at a time, times it in sixteenth
// steps at a latched tempo, shapes the gate and pulses step/done events.
module note_length_timer
  import music_timer_pkg::*;
#(
  parameter int unsigned TICK_W = 26,
  parameter int unsigned STEP_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic [3:0]        length,
  input  logic [1:0]        artic,
  input  logic [TICK_W-1:0] tick_len,
  input  logic              pause,
  input  logic              abort,
  output logic              busy,
  output logic              gate,
  output logic              step_tick,
  output logic              note_done
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   steps_q, steps_d, nsteps_q, nsteps_d;
  logic [TICK_W-1:0]   tlen_q, tlen_d;
  artic_e              artic_q, artic_d;

  logic [TICK_W-1:0]   cnt, cnt_nxt;
  logic                wrap, psc_clear, psc_en, moving;
  logic [STEP_W-1:0]   code_steps;
  logic [TICK_W-1:0]   tick_sat;
  logic                last, accept;
  logic                busy_d, gate_d, tick_d, done_d, wrap_nxt;

  tick_prescaler #(.TICK_W(TICK_W)) u_psc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (psc_clear),
    .en        (psc_en),
    .tick_len  (tlen_q),
    .count     (cnt),
    .count_nxt (cnt_nxt),
    .wrap      (wrap)
  );

  assign code_steps = STEP_W'(len_to_steps(length));
  assign tick_sat   = (tick_len == '0) ? TICK_W'(1) : tick_len;
  assign last       = (state_q == ST_PLAY) && wrap && (steps_q == STEP_W'(1));
  assign note_ready = (state_q == ST_IDLE) || (last && !pause);
  assign accept     = note_valid && note_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      steps_q   <= '0;
      nsteps_q  <= '0;
      tlen_q    <= '0;
      artic_q   <= ARTIC_LEGATO;
      busy      <= 1'b0;
      gate      <= 1'b0;
      step_tick <= 1'b0;
      note_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      steps_q   <= steps_d;
      nsteps_q  <= nsteps_d;
      tlen_q    <= tlen_d;
      artic_q   <= artic_d;
      busy      <= busy_d;
      gate      <= gate_d;
      step_tick <= tick_d;
      note_done <= done_d;
    end
  end

  // moving marks an edge that enters a new timed cycle; paused edges hold the
  // counters and never re-issue a tick, so events shift by the pause length.
  always_comb begin
    state_d   = state_q;
    steps_d   = steps_q;
    nsteps_d  = nsteps_q;
    tlen_d    = tlen_q;
    artic_d   = artic_q;
    psc_clear = 1'b0;
    psc_en    = 1'b0;
    moving    = 1'b0;
    if (abort) begin
      state_d   = ST_IDLE;
      psc_clear = 1'b1;
    end else if (accept) begin
      psc_clear = 1'b1;
      if (code_steps != '0) begin
        state_d  = ST_PLAY;
        steps_d  = code_steps;
        nsteps_d = code_steps;
        tlen_d   = tick_sat;
        artic_d  = artic_e'(artic);
        moving   = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_PLAY && !pause) begin
      if (last) begin
        state_d   = ST_IDLE;
        psc_clear = 1'b1;
      end else begin
        moving = 1'b1;
        psc_en = 1'b1;
        if (wrap) steps_d = steps_q - STEP_W'(1);
      end
    end
  end

  // Outputs are decoded from the values the next cycle will hold.
  always_comb begin
    busy_d   = (state_d == ST_PLAY);
    wrap_nxt = (cnt_nxt == tlen_d - TICK_W'(1));
    tick_d   = 1'b0;
    done_d   = 1'b0;
    gate_d   = 1'b0;
    if (state_d == ST_PLAY && moving) begin
      tick_d = wrap_nxt;
      done_d = wrap_nxt && (steps_d == STEP_W'(1));
      case (artic_d)
        ARTIC_LEGATO:   gate_d = 1'b1;
        ARTIC_NORMAL:   gate_d = !((steps_d == STEP_W'(1)) &&
                                   (cnt_nxt >= tlen_d - (tlen_d >> 2)));
        ARTIC_STACCATO: gate_d = (steps_d == nsteps_d);
        default:        gate_d = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_note_length_timer.sv
// Directed self-checking bench for note_length_timer.
module tb_note_length_timer;

  localparam int unsigned TW = 26;
  localparam int unsigned SW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          note_valid = 1'b0;
  logic          note_ready;
  logic [3:0]    length = 4'd0;
  logic [1:0]    artic = 2'd0;
  logic [TW-1:0] tick_len = '0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic          busy, gate, step_tick, note_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  note_length_timer #(.TICK_W(TW), .STEP_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .length     (length),
    .artic      (artic),
    .tick_len   (tick_len),
    .pause      (pause),
    .abort      (abort),
    .busy       (busy),
    .gate       (gate),
    .step_tick  (step_tick),
    .note_done  (note_done)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input logic b, input logic g,
                         input logic t, input logic d, input logic r);
    check($sformatf("%s.busy@%0d", tag, c), busy, b);
    check($sformatf("%s.gate@%0d", tag, c), gate, g);
    check($sformatf("%s.tick@%0d", tag, c), step_tick, t);
    check($sformatf("%s.done@%0d", tag, c), note_done, d);
    check($sformatf("%s.ready@%0d", tag, c), note_ready, r);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [3:0] len, input logic [1:0] a, input logic [TW-1:0] t);
    note_valid = 1'b1;
    length     = len;
    artic      = a;
    tick_len   = t;
    #1;
    check("offer.ready", note_ready, 1'b1);
    step();
    note_valid = 1'b0;
    #1;
  endtask

  initial begin
    int eff;
    // reset state
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // quarter, legato, T=4
    offer(4'd3, 2'd0, TW'(4));
    for (int k = 1; k <= 16; k++) begin
      chk_all("quarter", k, 1'b1, 1'b1, (k % 4) == 0, k == 16, k == 16);
      step();
    end
    chk_all("quarter_end", 17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // eighth then dotted eighth back to back, T=5
    offer(4'd4, 2'd0, TW'(5));
    for (int k = 1; k <= 25; k++) begin
      if (k == 10) begin
        note_valid = 1'b1;
        length     = 4'd7;
        artic      = 2'd0;
        tick_len   = TW'(5);
        #1;
      end
      chk_all("b2b", k, 1'b1, 1'b1, (k % 5) == 0, k == 10 || k == 25, k == 10 || k == 25);
      step();
      note_valid = 1'b0;
    end
    chk_all("b2b_end", 26, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // half, staccato, T=8: gate only during the first step
    offer(4'd2, 2'd2, TW'(8));
    for (int k = 1; k <= 64; k++) begin
      check($sformatf("stacc.gate@%0d", k), gate, k <= 8);
      check($sformatf("stacc.done@%0d", k), note_done, k == 64);
      step();
    end
    check("stacc.busy_end", busy, 1'b0);

    // half, normal, T=8: gate drops for the final 2 cycles
    offer(4'd2, 2'd1, TW'(8));
    for (int k = 1; k <= 64; k++) begin
      check($sformatf("normal.gate@%0d", k), gate, k < 63);
      check($sformatf("normal.busy@%0d", k), busy, 1'b1);
      step();
    end
    check("normal.busy_end", busy, 1'b0);

    // quarter, rest, T=2: gate never high
    offer(4'd3, 2'd3, TW'(2));
    for (int k = 1; k <= 8; k++) begin
      chk_all("rest", k, 1'b1, 1'b0, (k % 2) == 0, k == 8, k == 8);
      step();
    end
    check("rest.busy_end", busy, 1'b0);

    // quarter, legato, T=4, pause held for 7 cycles from cycle 6
    offer(4'd3, 2'd0, TW'(4));
    for (int c = 1; c <= 23; c++) begin
      pause = (c >= 6 && c <= 12);
      #1;
      eff = (c <= 6) ? c : ((c <= 13) ? 0 : c - 7);
      chk_all("pause", c, 1'b1, eff > 0, eff > 0 && (eff % 4) == 0, eff == 16, eff == 16);
      step();
    end
    pause = 1'b0;
    check("pause.busy_end", busy, 1'b0);

    // abort at cycle 6 of a whole note; offered note in that cycle ignored
    offer(4'd1, 2'd0, TW'(2));
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) begin
        abort      = 1'b1;
        note_valid = 1'b1;
        length     = 4'd3;
        #1;
      end
      check($sformatf("abort.busy@%0d", c), busy, 1'b1);
      step();
    end
    abort      = 1'b0;
    note_valid = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      chk_all("abort_after", c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end

    // abort beats a same-cycle accept in IDLE
    abort      = 1'b1;
    note_valid = 1'b1;
    length     = 4'd3;
    tick_len   = TW'(2);
    step();
    abort      = 1'b0;
    note_valid = 1'b0;
    #1;
    check("abort_idle.busy", busy, 1'b0);

    // asynchronous reset mid-note
    offer(4'd1, 2'd0, TW'(2));
    for (int c = 1; c <= 5; c++) step();
    check("rst_pre.busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    chk_all("rst_after", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // NONE codes are accepted as stop commands with no activity
    offer(4'd0, 2'd0, TW'(3));
    chk_all("code0", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    offer(4'd12, 2'd0, TW'(3));
    chk_all("code12", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // tick_len=0 acts as T=1: a sixteenth lasts one cycle
    offer(4'd8, 2'd0, TW'(0));
    chk_all("t0_16th", 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    chk_all("t0_end", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // T=1 eighth: two cycles, tick each cycle
    offer(4'd4, 2'd0, TW'(1));
    chk_all("t1_eighth", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("t1_eighth", 2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check("t1_eighth.busy_end", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
